// File: rtl/tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tx_framer
// Description : Buffers one frame of payload bytes received over a
//               valid/ready handshake, then serialises it MSB-first as
//               preamble, sync word, length byte, payload and CRC-8, one bit
//               per bit_en tick, onto the encoder serial input.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous active-high reset
//               bit_en     - bit-rate tick; the serial output advances on it
//               in_data    - payload byte
//               in_valid   - in_data valid
//               in_last    - final byte of the frame
//               in_ready   - byte accepted when in_valid && in_ready
//               data_o     - serial bit stream
//               busy       - high from frame commit until frame end
//               frame_done - one-cycle pulse at frame end
// Revision    : 1.0 - initial release
// ============================================================================
module tx_framer #(
  parameter int          PREAMBLE_LEN = 16,
  parameter logic [15:0] SYNC_WORD    = 16'hE5A3,
  parameter int          MAX_LEN      = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       data_o,
  output logic       busy,
  output logic       frame_done
);

  localparam int c_idx_w   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int c_cnt_max = (PREAMBLE_LEN > 16) ? PREAMBLE_LEN : 16;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_pre_last  = c_cnt_w'(PREAMBLE_LEN);
  localparam logic [c_cnt_w-1:0] c_sync_last = c_cnt_w'(16);
  localparam logic [c_cnt_w-1:0] c_byte_last = c_cnt_w'(8);
  localparam logic [7:0]         c_max_last  = 8'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SYNC     = 3'd2,
    S_LEN      = 3'd3,
    S_PAYLOAD  = 3'd4,
    S_CRC      = 3'd5
  } state_t;

  logic [7:0] r_buf [0:MAX_LEN-1];

  state_t             r_state,     w_state;
  logic               r_data,      w_data;
  logic               r_done,      w_done;
  logic               r_committed, w_committed;
  logic [7:0]         r_count,     w_count;
  logic [7:0]         r_len,       w_len;
  logic [c_cnt_w-1:0] r_bitcnt,    w_bitcnt;
  logic [c_idx_w-1:0] r_byte_idx,  w_byte_idx;
  logic [15:0]        r_shift,     w_shift;   // outgoing bits leave from [15]
  logic [7:0]         r_crc,       w_crc;

  logic               w_accept;
  logic [c_idx_w-1:0] w_next_idx;
  logic [7:0]         w_first_byte;
  logic [7:0]         w_next_byte;

  // CRC-8, polynomial 0x07, one message bit per step
  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // in_ready also drops during the frame_done cycle
  assign in_ready     = ~reset & ~r_committed & ~r_done;
  assign w_accept     = in_valid & in_ready;
  assign busy         = r_committed;
  assign data_o       = r_data;
  assign frame_done   = r_done;
  assign w_next_idx   = r_byte_idx + 1'b1;
  assign w_first_byte = r_buf[0];
  assign w_next_byte  = r_buf[w_next_idx];

  always_comb begin
    w_state     = r_state;
    w_data      = r_data;
    w_done      = 1'b0;
    w_committed = r_committed;
    w_count     = r_count;
    w_len       = r_len;
    w_bitcnt    = r_bitcnt;
    w_byte_idx  = r_byte_idx;
    w_shift     = r_shift;
    w_crc       = r_crc;

    if (w_accept) begin
      w_count = r_count + 8'd1;
      if (in_last || (r_count == c_max_last)) begin
        w_committed = 1'b1;
        w_len       = r_count + 8'd1;
      end
    end

    if (bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (r_committed) begin
            w_state  = S_PREAMBLE;
            w_data   = 1'b1;
            w_bitcnt = c_one;
          end else begin
            w_data = 1'b0;
          end
        end
        S_PREAMBLE: begin
          if (r_bitcnt == c_pre_last) begin
            w_state  = S_SYNC;
            w_data   = SYNC_WORD[15];
            w_shift  = {SYNC_WORD[14:0], 1'b0};
            w_bitcnt = c_one;
          end else begin
            w_data   = ~r_data;
            w_bitcnt = r_bitcnt + c_one;
          end
        end
        S_SYNC: begin
          if (r_bitcnt == c_sync_last) begin
            w_state  = S_LEN;
            w_data   = r_len[7];
            w_crc    = crc_step(r_crc, r_len[7]);
            w_shift  = {r_len[6:0], 9'd0};
            w_bitcnt = c_one;
          end else begin
            w_data   = r_shift[15];
            w_shift  = {r_shift[14:0], 1'b0};
            w_bitcnt = r_bitcnt + c_one;
          end
        end
        S_LEN: begin
          if (r_bitcnt == c_byte_last) begin
            w_state    = S_PAYLOAD;
            w_byte_idx = '0;
            w_data     = w_first_byte[7];
            w_crc      = crc_step(r_crc, w_first_byte[7]);
            w_shift    = {w_first_byte[6:0], 9'd0};
            w_bitcnt   = c_one;
          end else begin
            w_data   = r_shift[15];
            w_crc    = crc_step(r_crc, r_shift[15]);
            w_shift  = {r_shift[14:0], 1'b0};
            w_bitcnt = r_bitcnt + c_one;
          end
        end
        S_PAYLOAD: begin
          if (r_bitcnt == c_byte_last) begin
            if (8'(r_byte_idx) == (r_len - 8'd1)) begin
              // CRC now covers every payload bit already on the wire
              w_state  = S_CRC;
              w_data   = r_crc[7];
              w_shift  = {r_crc[6:0], 9'd0};
              w_bitcnt = c_one;
            end else begin
              w_byte_idx = w_next_idx;
              w_data     = w_next_byte[7];
              w_crc      = crc_step(r_crc, w_next_byte[7]);
              w_shift    = {w_next_byte[6:0], 9'd0};
              w_bitcnt   = c_one;
            end
          end else begin
            w_data   = r_shift[15];
            w_crc    = crc_step(r_crc, r_shift[15]);
            w_shift  = {r_shift[14:0], 1'b0};
            w_bitcnt = r_bitcnt + c_one;
          end
        end
        S_CRC: begin
          if (r_bitcnt == c_byte_last) begin
            w_state     = S_IDLE;
            w_data      = 1'b0;
            w_done      = 1'b1;
            w_committed = 1'b0;
            w_count     = 8'd0;
            w_crc       = 8'h00;
            w_bitcnt    = '0;
          end else begin
            w_data   = r_shift[15];
            w_shift  = {r_shift[14:0], 1'b0};
            w_bitcnt = r_bitcnt + c_one;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_data  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_data      <= 1'b0;
      r_done      <= 1'b0;
      r_committed <= 1'b0;
      r_count     <= 8'd0;
      r_len       <= 8'd0;
      r_bitcnt    <= '0;
      r_byte_idx  <= '0;
      r_shift     <= 16'd0;
      r_crc       <= 8'h00;
    end else begin
      r_state     <= w_state;
      r_data      <= w_data;
      r_done      <= w_done;
      r_committed <= w_committed;
      r_count     <= w_count;
      r_len       <= w_len;
      r_bitcnt    <= w_bitcnt;
      r_byte_idx  <= w_byte_idx;
      r_shift     <= w_shift;
      r_crc       <= w_crc;
    end
  end

  // Payload storage needs no reset: the byte count alone defines validity
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_count[c_idx_w-1:0]] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_framer
// Description : Self-checking bench for tx_framer. Directed vectors with
//               hand-computed CRCs, MAX_LEN split, mid-frame reset and random
//               frames checked against a bit-serial reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_framer;

  localparam int          PRE  = 16;
  localparam logic [15:0] SYNC = 16'hE5A3;
  localparam int          MAXL = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       data_o;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  tx_framer #(
    .PREAMBLE_LEN(PRE),
    .SYNC_WORD   (SYNC),
    .MAX_LEN     (MAXL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_en    (bit_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .data_o    (data_o),
    .busy      (busy),
    .frame_done(frame_done)
  );

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    int         period;
    int         exp_crc;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  bit         rx_bits[$];
  bit         exp_bits[$];
  bit         hold_ok;
  bit         busy_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc_bit(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic void build_exp();
    logic [7:0] crc;
    logic [7:0] len;
    logic [7:0] b;
    crc = 8'h00;
    exp_bits.delete();
    for (int i = 0; i < PRE; i++) exp_bits.push_back((i % 2) == 0);
    for (int i = 15; i >= 0; i--) exp_bits.push_back(SYNC[i]);
    len = 8'(tx_q.size());
    for (int i = 7; i >= 0; i--) begin
      exp_bits.push_back(len[i]);
      crc = ref_crc_bit(crc, len[i]);
    end
    for (int k = 0; k < tx_q.size(); k++) begin
      b = tx_q[k];
      for (int i = 7; i >= 0; i--) begin
        exp_bits.push_back(b[i]);
        crc = ref_crc_bit(crc, b[i]);
      end
    end
    for (int i = 7; i >= 0; i--) exp_bits.push_back(crc[i]);
  endfunction

  function automatic logic [7:0] rx_byte(input int start);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (start + i < rx_bits.size()) v = {v[6:0], rx_bits[start + i]};
      else v = {v[6:0], 1'b0};
    end
    return v;
  endfunction

  // Presents one byte and holds it until the DUT accepts it
  task automatic offer(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("offer_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // period 0 = random bit_en; max_bits > 0 stops early after that many bits
  task automatic collect(input int period, input int max_bits);
    int   cyc;
    logic en;
    logic prev;
    bit   ended;
    rx_bits.delete();
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    cyc     = 0;
    ended   = 1'b0;
    prev    = data_o;
    while (!ended) begin
      en = (period == 0) ? ($urandom_range(2) != 0) : ((cyc % period) == period - 1);
      bit_en = en;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (frame_done) begin
        ended = 1'b1;
      end else begin
        if (en) rx_bits.push_back(data_o);
        else if (data_o !== prev) hold_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        prev = data_o;
        if (max_bits > 0 && rx_bits.size() == max_bits) begin
          bit_en = 1'b0;
          return;
        end
        if (cyc > 20000) begin
          check("collect_timeout", 32'd0, 32'd1);
          bit_en = 1'b0;
          return;
        end
      end
    end
    bit_en = 1'b0;
    check("done_cycle_busy", 32'(busy), 32'd0);
    check("done_cycle_ready", 32'(in_ready), 32'd0);
    check("done_cycle_data", 32'(data_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("done_single_pulse", 32'(frame_done), 32'd0);
    check("ready_after_done", 32'(in_ready), 32'd1);
  endtask

  task automatic verify(input string name, input int exp_crc);
    int mism;
    build_exp();
    mism = 0;
    check({name, "_bitcount"}, 32'(rx_bits.size()), 32'(exp_bits.size()));
    for (int i = 0; i < rx_bits.size() && i < exp_bits.size(); i++)
      if (rx_bits[i] != exp_bits[i]) mism++;
    check({name, "_stream_errs"}, 32'(mism), 32'd0);
    check({name, "_hold"}, 32'(hold_ok), 32'd1);
    check({name, "_busy"}, 32'(busy_ok), 32'd1);
    if (exp_crc >= 0)
      check({name, "_crc"}, 32'(rx_byte(rx_bits.size() - 8)), 32'(exp_crc));
  endtask

  task automatic send_frame(input int period);
    for (int i = 0; i < tx_q.size(); i++) offer(tx_q[i], i == tx_q.size() - 1);
    collect(period, 0);
  endtask

  vec_t vecs[5];

  initial begin
    // CRC values hand-computed from the 0x07 byte table
    vecs[0] = '{n: 1, b0: 8'h00, b1: 8'h00, period: 1, exp_crc: 'h15};
    vecs[1] = '{n: 1, b0: 8'h01, b1: 8'h00, period: 1, exp_crc: 'h12};
    vecs[2] = '{n: 1, b0: 8'h00, b1: 8'h00, period: 4, exp_crc: 'h15};
    vecs[3] = '{n: 2, b0: 8'h01, b1: 8'h02, period: 1, exp_crc: 'hCD};
    vecs[4] = '{n: 2, b0: 8'h01, b1: 8'h02, period: 3, exp_crc: 'hCD};

    reset    = 1'b1;
    bit_en   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // bit_en while idle and empty leaves the line low
    @(negedge clk);
    bit_en = 1'b1;
    repeat (3) @(negedge clk);
    bit_en = 1'b0;
    check("idle_data", 32'(data_o), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 5; v++) begin
      tx_q.delete();
      tx_q.push_back(vecs[v].b0);
      if (vecs[v].n > 1) tx_q.push_back(vecs[v].b1);
      send_frame(vecs[v].period);
      verify($sformatf("vec%0d", v), vecs[v].exp_crc);
      check($sformatf("vec%0d_total", v), 32'(rx_bits.size()), 32'(PRE + 32 + 8 * vecs[v].n));
    end

    // 70 bytes with no in_last: split at MAX_LEN
    tx_q.delete();
    for (int i = 1; i <= 64; i++) begin
      tx_q.push_back(8'(i * 3 + 7));
      offer(8'(i * 3 + 7), 1'b0);
    end
    check("max_ready_low", 32'(in_ready), 32'd0);
    check("max_busy_high", 32'(busy), 32'd1);
    in_data  = 8'(65 * 3 + 7);
    in_valid = 1'b1;
    collect(1, 0);
    verify("max_frame1", -1);
    check("max_len_field", 32'(rx_byte(PRE + 16)), 32'h40);
    tx_q.delete();
    for (int i = 65; i <= 70; i++) begin
      tx_q.push_back(8'(i * 3 + 7));
      offer(8'(i * 3 + 7), i == 70);
    end
    collect(1, 0);
    verify("max_frame2", -1);
    check("max2_len_field", 32'(rx_byte(PRE + 16)), 32'h06);

    // Reset while payload bit 3 is on the line
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'h77);
    for (int i = 0; i < 3; i++) offer(tx_q[i], i == 2);
    collect(1, PRE + 16 + 8 + 4);
    check("mid_payload_bit3", 32'(data_o), 32'd0);  // 0xA5 bit 4 (MSB-first idx 3) is 0
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_data", 32'(data_o), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    tx_q.delete();
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h02);
    send_frame(1);
    verify("post_abort", 'hCD);

    // Random frames with input dropouts and random bit_en gaps
    for (int f = 0; f < 200; f++) begin
      int n;
      n = $urandom_range(8, 1);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(255)));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(2)) @(negedge clk);
        offer(tx_q[i], i == n - 1);
      end
      collect(0, 0);
      verify($sformatf("rand%0d", f), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_framer.md
Name: tx_framer

Overview:
- Upstream stage of the transmit chain. Accepts payload bytes over a valid/ready handshake and buffers one complete frame.
- Serialises the frame MSB-first onto a single bit line, paced by a bit-rate enable. That bit line drives the encoder's serial input.
- Frame on the wire: preamble, sync word, length byte, payload, CRC-8.
- Runs on the encoder clock domain.

Parameters:
- PREAMBLE_LEN, 16: number of preamble bits; alternating, first bit 1; must be even and ≥2.
- SYNC_WORD, 16'hE5A3: 16-bit sync pattern, sent MSB first.
- MAX_LEN, 64: payload buffer depth in bytes, 1..255.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- bit_en, input, 1: one-cycle bit tick; the serial output advances only on cycles where this is 1.
- in_data, input, 8: payload byte.
- in_valid, input, 1: in_data valid.
- in_last, input, 1: qualifies the final byte of the frame.
- in_ready, output, 1: a byte is accepted on cycles where in_valid && in_ready.
- data_o, output, 1: serial bit stream to the encoder.
- busy, output, 1: high from frame commit until frame end.
- frame_done, output, 1: one-cycle pulse when the last CRC bit has been held for its full bit period.

Behaviour:
- Reset values: data_o=0, busy=0, frame_done=0, in_ready=0 during reset and 1 the cycle after. Buffer count=0, CRC=8'h00, state=IDLE.
- Reset mid-frame aborts the frame immediately and discards buffered bytes. data_o=0 on the next cycle.
- Load phase (state IDLE, not committed):
  - in_ready=1.
  - Each accepted byte is written to buffer[count]; count increments.
  - The frame commits on acceptance of an in_last byte, or of byte number MAX_LEN. In the MAX_LEN case, any subsequent bytes belong to the next frame.
  - After commit, in_ready=0 until frame_done.
  - Zero-length frames cannot occur.
- Commit: busy=1 on the cycle after the committing byte; LEN is latched as count (1..MAX_LEN).
- State machine (IDLE, PREAMBLE, SYNC, LEN, PAYLOAD, CRC):
  - Transitions and bit shifts occur only on clk edges where bit_en=1.
  - data_o is registered and changes only on bit_en edges. Each bit is held until the next bit_en.
  - IDLE, committed, bit_en → PREAMBLE; data_o=1 (preamble bit 0).
  - PREAMBLE: bits alternate 1,0,1,0…; after PREAMBLE_LEN bits → SYNC.
  - SYNC: 16 bits of SYNC_WORD, MSB first → LEN.
  - LEN: 8 bits of LEN, MSB first → PAYLOAD.
  - PAYLOAD: buffer[0..LEN-1], each MSB first → CRC.
  - CRC: 8 bits of the CRC register, MSB first. On the bit_en after the last CRC bit: data_o=0, state=IDLE, busy=0, frame_done=1 for that cycle, count=0, in_ready=1 from the next cycle.
- bit_en while IDLE and uncommitted: data_o stays 0.
- bit_en asserted on consecutive cycles is legal: one bit per cycle.
- CRC-8:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Covers the LEN byte then the payload bytes.
  - May be computed bitwise as bits are shifted out (LEN/PAYLOAD states) or bytewise during load. The value sent must equal the reference computation.
  - Reset to 0x00 at frame end and on reset.
- Frame length on the wire = PREAMBLE_LEN + 16 + 8 + 8·LEN + 8 bits.
- Simultaneous events:
  - in_valid at the same edge as frame_done: not accepted, since in_ready=0 that cycle.
  - in_valid with in_ready=0: ignored; upstream must hold the byte.
- Buffer is single-frame; there is no overlap between loading and sending.

Test Plan:
- Single byte 0x00 with in_last, bit_en every cycle → 16 preamble bits 1010…, then E5A3, then 0x01, 0x00, CRC 0x15. Total 56 bits. frame_done pulses once; busy is high for exactly 56 bit periods.
- Single byte 0x01 with in_last → LEN 0x01, payload 0x01, CRC 0x12 (table[0x07^0x01]=table[0x06]=0x12). Compare against a bit-serial reference model.
- 70 bytes without in_last, MAX_LEN=64 → frame 1 carries 64 bytes with LEN 0x40. in_ready=0 after byte 64. Bytes 65–70 are accepted only after frame_done and form frame 2.
- bit_en every 4th cycle → data_o constant over each 4-cycle window. Bit order and count match the first scenario exactly.
- Reset asserted during PAYLOAD bit 3 → next cycle data_o=0, busy=0, in_ready=1. A new 2-byte frame afterwards transmits correctly with a fresh CRC.
- in_valid held with random bit_en gaps and in_valid dropouts → no byte lost or duplicated. Serial payload equals the input sequence over 200 random frames, checked by the reference model.
